digit_serial_adder: RTL
=======================

# digit_serial_adder

Parametrised, multi-cycle successor to the team's single-bit half adder. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB first, keeping the carry in a register between cycles. A start/busy/done handshake lets area-constrained datapaths trade latency for adder width. Carry-out and signed overflow are reported alongside the sum.

## Interface
- WIDTH, 8: operand and sum width in bits, ≥ 1.
- DIGIT, 1: bits processed per cycle. 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0, otherwise elaboration fails with an error. N = WIDTH/DIGIT.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; one clock domain only.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, sampled at the accepting edge.
- b  input  WIDTH  operand B, sampled at the accepting edge.
- sub  input  1  0 = A+B, 1 = A−B; sampled at the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry  output  1  carry-out of the MSB. For subtraction, 1 = no borrow.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, any state): state = IDLE. busy, done, sum, carry and overflow are 0. Operand shift registers, carry register and digit counter are 0.
- IDLE, start=1: latch a into the A-register. Latch b into the B-register, or ~b if sub=1. Load carry register = sub. Clear the digit counter and sum register. Go to RUN.
- IDLE, start=0: stay in IDLE; outputs hold.
- RUN, each cycle:
  - Add DIGIT LSBs of the A- and B-registers plus the carry register with a DIGIT-bit ripple adder.
  - Write the DIGIT-bit result into the sum register at digit position = counter. The sum register shifts right by DIGIT with the result entering at the top, so after N cycles bit 0 is the LSB.
  - Update the carry register. Shift the A- and B-registers right by DIGIT. Increment the counter.
- On the last digit (counter = N−1):
  - Capture overflow from the carry into bit WIDTH−1 and the carry out.
  - Transfer the completed sum and carry to the outputs.
  - Go to DONE.
- DONE: done = 1 for exactly this cycle.
  - start=1: accept the new operation exactly as in IDLE (back-to-back) and go to RUN.
  - start=0: go to IDLE.
- start in RUN is ignored; no queueing.
- sum, carry and overflow hold their last result until the next completion or reset. They do not change during RUN.
- a, b and sub may change freely after the accepting edge.
- DIGIT = WIDTH gives N = 1: one RUN cycle, then DONE.

## Timing
- Accepting edge E0 (start=1 in IDLE/DONE). busy=1 from E0 to E_N, i.e. N cycles.
- At E_N: busy=0, done=1, outputs updated. done=0 after E_{N+1}.
- Latency from accepting edge to done visible: N cycles. Throughput with continuous start: one result per N+1 cycles.
- Reset asserted mid-RUN: immediate abort, no done pulse, outputs cleared to 0. First start is accepted at the first rising edge after rst deasserts.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst mid-cycle with random inputs. Required: busy, done, sum, carry and overflow all read 0 asynchronously, before the next edge.
- WIDTH=8, DIGIT=1, add:
  - a=0x7F, b=0x01, sub=0: busy for 8 cycles, then done pulse with sum=0x80, carry=0, overflow=1.
  - a=0xFF, b=0x01: sum=0x00, carry=1, overflow=0.
- WIDTH=8, DIGIT=1, subtract:
  - a=0x05, b=0x07, sub=1: sum=0xFE, carry=0 (borrow), overflow=0.
  - a=0x80, b=0x01, sub=1: sum=0x7F, carry=1, overflow=1.
- WIDTH=8, DIGIT=4:
  - a=0x3C, b=0x4D, sub=0: busy for 2 cycles, sum=0x89, carry=0, overflow=1.
  - Start held high continuously: results every 3 cycles. Changing a/b during RUN does not affect the result.
- Handshake: pulse start during RUN with different operands. Required: ignored, and the original result is produced. A start in the DONE cycle is accepted, with no idle cycle.
- Exhaustive check, WIDTH=4, DIGIT ∈ {1,2,4}: all 512 combinations of a, b and sub. Compare sum, carry and overflow against a reference model. Confirm the result in each case and the absence of a done pulse when rst is asserted mid-RUN.

Source files
------------

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per
// clock, least significant digit first. The carry is held in a register
// between digits. Each operation is accepted with start, runs for
// WIDTH/DIGIT cycles with busy high, and finishes with a one-cycle done pulse.
// sum, carry and overflow are registered and hold their value until the next
// operation completes.

module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  // A digit width that does not evenly divide the operand is rejected at
  // elaboration. Otherwise the final digit would be only partly filled.
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gBadParams
    $error("digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adderState;

  adderState        state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] sumReg;
  logic             carryReg;
  logic [CW-1:0]    digitCnt;

  logic [DIGIT-1:0] digitSum;
  logic             digitCarryOut;
  logic             msbCarryIn;
  logic [WIDTH-1:0] nextSum;

  // Ripple-add the low digit of both operand registers plus the stored carry.
  // The carry into the top bit of the digit is also kept. On the last digit
  // that bit is the operand MSB, so it is the carry used for the overflow flag.
  always_comb begin
    logic [DIGIT:0] chain;
    chain         = '0;
    digitSum      = '0;
    chain[0]      = carryReg;
    for (int i = 0; i < DIGIT; i++) begin
      digitSum[i]  = aReg[i] ^ bReg[i] ^ chain[i];
      chain[i+1]   = (aReg[i] & bReg[i]) | (chain[i] & (aReg[i] ^ bReg[i]));
    end
    digitCarryOut = chain[DIGIT];
    msbCarryIn    = chain[DIGIT-1];
  end

  // The new digit enters the sum register at the top while the register shifts
  // right. After N digits the first digit has reached bit 0.
  assign nextSum = (sumReg >> DIGIT) | (WIDTH'(digitSum) << (WIDTH - DIGIT));

  // This block holds the control FSM and the datapath registers. In IDLE or
  // DONE a start loads the operands, with B inverted and carry-in set for
  // subtraction. RUN consumes one digit per cycle. On the last digit the
  // completed result is published to the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      aReg     <= '0;
      bReg     <= '0;
      sumReg   <= '0;
      carryReg <= 1'b0;
      digitCnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            aReg     <= a;
            bReg     <= sub ? ~b : b;
            carryReg <= sub;
            sumReg   <= '0;
            digitCnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          sumReg   <= nextSum;
          carryReg <= digitCarryOut;
          aReg     <= aReg >> DIGIT;
          bReg     <= bReg >> DIGIT;
          digitCnt <= digitCnt + CW'(1);
          if (digitCnt == LAST_DIGIT) begin
            sum      <= nextSum;
            carry    <= digitCarryOut;
            overflow <= msbCarryIn ^ digitCarryOut;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
